train_center_cal_tx: RTL and testbench

- Transmitter-side partner of the MBTRAIN center-calibration receiver FSM.
- Issues the start and end requests over the sideband and consumes the partner's responses.
- Between the two handshakes, enables the local point-test and eye-width-sweep logic and captures the per-lane result.
- Asserts a test-done acknowledge for the MBTRAIN sequencer.

---
 rtl/train_center_cal_tx_if.sv | 39 +++
 rtl/train_center_cal_tx.sv | 199 +++++++++++++++++++
 tb/tb_train_center_cal_tx.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/train_center_cal_tx_if.sv
// Sideband, point-test and sequencer signals of the center-cal transmitter.
// master: the calibration block; slave: its environment.
interface train_center_cal_tx_if #(
    parameter int LANES = 16
);
    logic             i_en;
    logic [3:0]       i_decoded_sideband_message;
    logic             i_sideband_valid;
    logic             i_busy_negedge_detected;
    logic             i_eye_sweep_req;
    logic             i_pt_done;
    logic [LANES-1:0] i_pt_lanes_result;
    logic [3:0]       o_sideband_message;
    logic             o_valid_tx;
    logic             o_pt_en;
    logic             o_eye_width_sweep_en;
    logic [LANES-1:0] o_lanes_result;
    logic             o_any_lane_pass;
    logic             o_test_ack;
    logic             o_timeout;

    modport master (
        input  i_en, i_decoded_sideband_message, i_sideband_valid,
        input  i_busy_negedge_detected, i_eye_sweep_req,
        input  i_pt_done, i_pt_lanes_result,
        output o_sideband_message, o_valid_tx, o_pt_en,
        output o_eye_width_sweep_en, o_lanes_result,
        output o_any_lane_pass, o_test_ack, o_timeout
    );

    modport slave (
        output i_en, i_decoded_sideband_message, i_sideband_valid,
        output i_busy_negedge_detected, i_eye_sweep_req,
        output i_pt_done, i_pt_lanes_result,
        input  o_sideband_message, o_valid_tx, o_pt_en,
        input  o_eye_width_sweep_en, o_lanes_result,
        input  o_any_lane_pass, o_test_ack, o_timeout
    );
endinterface

// File: rtl/train_center_cal_tx.sv
// MBTRAIN center-calibration transmitter FSM with registered outputs.
// Define TRAIN_CENTER_CAL_TIMEOUT_EN to add the sequence abort counter.
module train_center_cal_tx #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000,
    parameter int          LANES          = 16
) (
    input logic                   clk,
    input logic                   rst,
    train_center_cal_tx_if.master bus
);
    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        SEND_START_REQ  = 3'd1,
        WAIT_START_RESP = 3'd2,
        RUN_TEST        = 3'd3,
        SEND_END_REQ    = 3'd4,
        WAIT_END_RESP   = 3'd5,
        TEST_FINISHED   = 3'd6
    } state_t;

    localparam logic [3:0] START_REQ  = 4'b0001;
    localparam logic [3:0] START_RESP = 4'b0010;
    localparam logic [3:0] END_REQ    = 4'b0011;
    localparam logic [3:0] END_RESP   = 4'b0100;

    state_t           state, state_d;
    logic [3:0]       msg_q, msg_d;
    logic             vtx_q, vtx_d;
    logic             pt_q, pt_d;
    logic             sw_q, sw_d;
    logic             ack_q, ack_d;
    logic             any_q, any_d;
    logic [LANES-1:0] lanes_q, lanes_d;
    logic             start_rsp, end_rsp, sent, tmo;

    assign start_rsp = bus.i_sideband_valid &&
                       bus.i_decoded_sideband_message == START_RESP;
    assign end_rsp   = bus.i_sideband_valid &&
                       bus.i_decoded_sideband_message == END_RESP;
    // A serializer pulse only counts while our request is on the wire.
    assign sent      = vtx_q && bus.i_busy_negedge_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            msg_q   <= '0;
            vtx_q   <= 1'b0;
            pt_q    <= 1'b0;
            sw_q    <= 1'b0;
            ack_q   <= 1'b0;
            any_q   <= 1'b0;
            lanes_q <= '0;
        end else begin
            state   <= state_d;
            msg_q   <= msg_d;
            vtx_q   <= vtx_d;
            pt_q    <= pt_d;
            sw_q    <= sw_d;
            ack_q   <= ack_d;
            any_q   <= any_d;
            lanes_q <= lanes_d;
        end
    end

    always_comb begin
        state_d = state;
        if (!bus.i_en) begin
            state_d = IDLE;
        end else if (tmo) begin
            state_d = TEST_FINISHED;
        end else begin
            case (state)
                IDLE:            state_d = SEND_START_REQ;
                SEND_START_REQ:  if (sent) state_d = WAIT_START_RESP;
                WAIT_START_RESP: if (start_rsp) state_d = RUN_TEST;
                RUN_TEST:        if (bus.i_pt_done) state_d = SEND_END_REQ;
                SEND_END_REQ:    if (sent) state_d = WAIT_END_RESP;
                WAIT_END_RESP:   if (end_rsp) state_d = TEST_FINISHED;
                TEST_FINISHED:   state_d = TEST_FINISHED;
                default:         state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        msg_d   = msg_q;
        vtx_d   = vtx_q;
        pt_d    = pt_q;
        sw_d    = sw_q;
        ack_d   = ack_q;
        any_d   = any_q;
        lanes_d = lanes_q;
        if (!bus.i_en) begin
            // Abort keeps the last captured lane result visible.
            msg_d = '0;
            vtx_d = 1'b0;
            pt_d  = 1'b0;
            sw_d  = 1'b0;
            ack_d = 1'b0;
        end else if (tmo) begin
            vtx_d = 1'b0;
            pt_d  = 1'b0;
            sw_d  = 1'b0;
            ack_d = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    msg_d   = '0;
                    vtx_d   = 1'b0;
                    pt_d    = 1'b0;
                    sw_d    = 1'b0;
                    ack_d   = 1'b0;
                    lanes_d = '0;
                    any_d   = 1'b0;
                end
                SEND_START_REQ, SEND_END_REQ: begin
                    if (!vtx_q) begin
                        vtx_d = 1'b1;
                        msg_d = (state == SEND_START_REQ) ?
                                START_REQ : END_REQ;
                    end else if (bus.i_busy_negedge_detected) begin
                        vtx_d = 1'b0;
                    end
                end
                WAIT_START_RESP: begin
                    if (start_rsp) begin
                        pt_d = 1'b1;
                        sw_d = bus.i_eye_sweep_req;
                    end
                end
                RUN_TEST: begin
                    if (bus.i_pt_done) begin
                        lanes_d = bus.i_pt_lanes_result;
                        any_d   = |bus.i_pt_lanes_result;
                        pt_d    = 1'b0;
                        sw_d    = 1'b0;
                    end
                end
                WAIT_END_RESP: begin
                    if (end_rsp) begin
                        msg_d = '0;
                        ack_d = 1'b1;
                    end
                end
                TEST_FINISHED: ;
                default: begin
                    msg_d = '0;
                    vtx_d = 1'b0;
                    pt_d  = 1'b0;
                    sw_d  = 1'b0;
                    ack_d = 1'b0;
                end
            endcase
        end
    end

`ifdef TRAIN_CENTER_CAL_TIMEOUT_EN
    logic [23:0] cnt;
    logic        timeout_q;
    logic        active;

    assign active = state inside {SEND_START_REQ, WAIT_START_RESP,
                                  RUN_TEST, SEND_END_REQ, WAIT_END_RESP};
    assign tmo    = active && (cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
            end else if (active) begin
                cnt <= cnt + 24'd1;
            end
            if (!bus.i_en || state == IDLE) begin
                timeout_q <= 1'b0;
            end else if (tmo) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo            = 1'b0;
    assign bus.o_timeout  = 1'b0;
`endif

    assign bus.o_sideband_message   = msg_q;
    assign bus.o_valid_tx           = vtx_q;
    assign bus.o_pt_en              = pt_q;
    assign bus.o_eye_width_sweep_en = sw_q;
    assign bus.o_lanes_result       = lanes_q;
    assign bus.o_any_lane_pass      = any_q;
    assign bus.o_test_ack           = ack_q;
endmodule

// File: tb/tb_train_center_cal_tx.sv
// Scoreboard bench for train_center_cal_tx: randomized sequences,
// expected events queued by the driver and checked by a monitor.
module tb_train_center_cal_tx;
    localparam int LANES = 16;
    localparam int K_VTX = 0;
    localparam int K_PT  = 1;
    localparam int K_ACK = 2;

    typedef struct {
        int               kind;
        logic [3:0]       msg;
        logic             sweep;
        logic [LANES-1:0] lanes;
        logic             tmo;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    train_center_cal_tx_if #(.LANES(LANES)) bus();

    train_center_cal_tx #(
        .TIMEOUT_CYCLES(24'd100),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [LANES-1:0] model_lanes;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int k, input logic [3:0] m,
                                input logic s, input logic [LANES-1:0] l,
                                input logic t);
        exp_t e;
        e.kind  = k;
        e.msg   = m;
        e.sweep = s;
        e.lanes = l;
        e.tmo   = t;
        return e;
    endfunction

    function automatic logic sel(input int w);
        case (w)
            K_VTX:   return bus.o_valid_tx;
            K_PT:    return bus.o_pt_en;
            default: return bus.o_test_ack;
        endcase
    endfunction

    // One clock; single-cycle pulses are dropped afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.i_sideband_valid        = 1'b0;
        bus.i_busy_negedge_detected = 1'b0;
        bus.i_pt_done               = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] m, input logic v);
        bus.i_decoded_sideband_message = m;
        bus.i_sideband_valid           = v;
        tick();
    endtask

    task automatic pulse_busy();
        bus.i_busy_negedge_detected = 1'b1;
        tick();
    endtask

    task automatic wait_out(input int w, input string name);
        int n = 0;
        while (sel(w) !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(sel(w)), 1);
    endtask

    task automatic pop_check(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk("unexpected_event", 1, 0);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", k, e.kind);
        case (k)
            K_VTX: chk("tx_message", bus.o_sideband_message, e.msg);
            K_PT: begin
                chk("sweep_with_pt", bus.o_eye_width_sweep_en, e.sweep);
                chk("no_tx_in_test", bus.o_valid_tx, 0);
            end
            default: begin
                chk("ack_lanes", bus.o_lanes_result, e.lanes);
                chk("ack_any", bus.o_any_lane_pass, |e.lanes);
                chk("ack_timeout", bus.o_timeout, e.tmo);
                if (!e.tmo) chk("ack_msg", bus.o_sideband_message, 0);
            end
        endcase
    endtask

    initial begin : monitor
        logic pv, pp, pa, pen, pbusy, psbv;
        logic [3:0] pmsg;
        pv = 0; pp = 0; pa = 0; pen = 0;
        pbusy = 0; psbv = 0; pmsg = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.o_valid_tx && !pv) pop_check(K_VTX);
                if (bus.o_pt_en && !pp) pop_check(K_PT);
                if (bus.o_test_ack && !pa) begin
                    pop_check(K_ACK);
                    if (!bus.o_timeout)
                        chk("ack_latency",
                            32'(psbv && pmsg == 4'b0100), 1);
                end
                if (pv && !bus.o_valid_tx && pen && !bus.o_timeout)
                    chk("tx_fall_after_busy", 32'(pbusy), 1);
            end
            pv    = bus.o_valid_tx;
            pp    = bus.o_pt_en;
            pa    = bus.o_test_ack;
            pen   = bus.i_en;
            pbusy = bus.i_busy_negedge_detected;
            psbv  = bus.i_sideband_valid;
            pmsg  = bus.i_decoded_sideband_message;
        end
    end

    // mode: 0 full pass, 1 abort in test, 2 abort in start req, 3 reset
    task automatic run_txn(input int mode, input bit fixed,
                           input logic [LANES-1:0] fres, input logic fsw);
        logic [LANES-1:0] res;
        logic             sw;
        res = fixed ? fres : LANES'($urandom);
        sw  = fixed ? fsw : 1'($urandom_range(0, 1));
        repeat ($urandom_range(0, 2)) tick();
        bus.i_eye_sweep_req = sw;
        bus.i_en            = 1'b1;
        model_lanes         = '0;
        sb.push_back(mk(K_VTX, 4'b0001, 1'b0, '0, 1'b0));
        wait_out(K_VTX, "start_tx_rise");
        chk("lanes_clear_on_start", bus.o_lanes_result, 0);
        tick();
        repeat ($urandom_range(0, 2)) send_msg(4'b0010, 1'b1);
        if (mode == 2) begin
            bus.i_en = 1'b0;
            tick();
            tick();
            chk("abort_tx", bus.o_valid_tx, 0);
            chk("abort_msg", bus.o_sideband_message, 0);
            chk("abort_lanes", bus.o_lanes_result, model_lanes);
            return;
        end
        if (mode == 3) begin
            rst = 1'b1;
            #1;
            chk("rst_tx", bus.o_valid_tx, 0);
            chk("rst_msg", bus.o_sideband_message, 0);
            chk("rst_lanes", bus.o_lanes_result, 0);
            chk("rst_ack", bus.o_test_ack, 0);
            bus.i_en = 1'b0;
            tick();
            rst = 1'b0;
            tick();
            chk("post_rst_tx", bus.o_valid_tx, 0);
            return;
        end
        pulse_busy();
        chk("start_tx_fall", bus.o_valid_tx, 0);
        send_msg(4'b0100, 1'b1);
        send_msg(4'b0010, 1'b0);
        pulse_busy();
        chk("hold_pt", bus.o_pt_en, 0);
        chk("hold_tx", bus.o_valid_tx, 0);
        chk("hold_msg", bus.o_sideband_message, 4'b0001);
        sb.push_back(mk(K_PT, 4'b0000, sw, '0, 1'b0));
        send_msg(4'b0010, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
        if (mode == 1) begin
            bus.i_en = 1'b0;
            tick();
            chk("abort_pt", bus.o_pt_en, 0);
            chk("abort_sweep", bus.o_eye_width_sweep_en, 0);
            chk("abort_ack", bus.o_test_ack, 0);
            chk("abort_lanes", bus.o_lanes_result, model_lanes);
            return;
        end
        model_lanes = res;
        sb.push_back(mk(K_VTX, 4'b0011, 1'b0, '0, 1'b0));
        bus.i_pt_lanes_result = res;
        bus.i_pt_done         = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            bus.i_sideband_valid           = 1'b1;
            bus.i_decoded_sideband_message = 4'b0100;
        end
        tick();
        bus.i_pt_lanes_result = LANES'($urandom);
        chk("capture_lanes", bus.o_lanes_result, model_lanes);
        chk("capture_any", bus.o_any_lane_pass, |model_lanes);
        chk("pt_off", bus.o_pt_en, 0);
        wait_out(K_VTX, "end_tx_rise");
        repeat ($urandom_range(1, 3)) tick();
        pulse_busy();
        sb.push_back(mk(K_ACK, 4'b0000, 1'b0, model_lanes, 1'b0));
        send_msg(4'b0100, 1'b1);
        chk("ack_rise", bus.o_test_ack, 1);
        repeat (2) tick();
        chk("ack_hold", bus.o_test_ack, 1);
        bus.i_en = 1'b0;
        tick();
        chk("idle_ack", bus.o_test_ack, 0);
        chk("idle_lanes_kept", bus.o_lanes_result, model_lanes);
        chk("idle_any_kept", bus.o_any_lane_pass, |model_lanes);
    endtask

`ifdef TRAIN_CENTER_CAL_TIMEOUT_EN
    task automatic run_timeout();
        int n = 0;
        bus.i_en    = 1'b1;
        model_lanes = '0;
        sb.push_back(mk(K_VTX, 4'b0001, 1'b0, '0, 1'b0));
        sb.push_back(mk(K_ACK, 4'b0000, 1'b0, '0, 1'b1));
        while (bus.o_timeout !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("timeout_cycle", n, 101);
        chk("timeout_ack", bus.o_test_ack, 1);
        chk("timeout_tx", bus.o_valid_tx, 0);
        bus.i_en = 1'b0;
        tick();
        chk("timeout_clear", bus.o_timeout, 0);
    endtask
`endif

    initial begin
        int mode;
        rst                            = 1'b1;
        bus.i_en                       = 1'b0;
        bus.i_decoded_sideband_message = '0;
        bus.i_sideband_valid           = 1'b0;
        bus.i_busy_negedge_detected    = 1'b0;
        bus.i_eye_sweep_req            = 1'b0;
        bus.i_pt_done                  = 1'b0;
        bus.i_pt_lanes_result          = '0;
        model_lanes                    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_msg", bus.o_sideband_message, 0);
        chk("reset_tx", bus.o_valid_tx, 0);
        chk("reset_pt", bus.o_pt_en, 0);
        chk("reset_sweep", bus.o_eye_width_sweep_en, 0);
        chk("reset_lanes", bus.o_lanes_result, 0);
        chk("reset_any", bus.o_any_lane_pass, 0);
        chk("reset_ack", bus.o_test_ack, 0);
        chk("reset_timeout", bus.o_timeout, 0);
        rst = 1'b0;
        tick();
        run_txn(0, 1'b1, 16'h00F0, 1'b0);
        run_txn(0, 1'b1, 16'h0000, 1'b1);
        run_txn(1, 1'b0, '0, 1'b0);
        run_txn(2, 1'b0, '0, 1'b0);
        run_txn(3, 1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mode = $urandom_range(0, 9);
            if (mode <= 5) run_txn(0, 1'b0, '0, 1'b0);
            else if (mode <= 7) run_txn(1, 1'b0, '0, 1'b0);
            else if (mode == 8) run_txn(2, 1'b0, '0, 1'b0);
            else run_txn(3, 1'b0, '0, 1'b0);
        end
`ifdef TRAIN_CENTER_CAL_TIMEOUT_EN
        run_timeout();
`endif
        repeat (3) tick();
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
